// File: rtl/seg_dynamic_scan.sv
// Six-digit multiplexed 7-segment driver with a continuous binary-to-BCD converter.
// Define SEG_BLANK_ZERO_EN to blank leading zeros on digits 1..5.
module seg_dynamic_scan #(
  parameter int CNT_1MS_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int CW = (CNT_1MS_MAX < 1) ? 1 : $clog2(CNT_1MS_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CNT_1MS_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [19:0]   sr_q, sr_d;
  logic [23:0]   bcd_q, bcd_d;
  logic [23:0]   dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;

  logic [23:0]   adj;
  logic [3:0]    cur;
  logic [6:0]    pat;
  logic          blank;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    bcd_d     = bcd_q;
    dig_d     = dig_q;
    adj       = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    unique case (state_q)
      IDLE: begin
        sr_d      = (data > 20'd999_999) ? 20'd999_999 : data;
        bcd_d     = '0;
        bit_cnt_d = '0;
        state_d   = CONV;
      end
      CONV: begin
        bcd_d     = {adj[22:0], sr_q[19]};
        sr_d      = {sr_q[18:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd19) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        dig_d   = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    cur = dig_q[{idx_q, 2'b00} +: 4];
    unique case (cur)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h7F;
    endcase
`ifdef SEG_BLANK_ZERO_EN
    blank = (idx_q != 3'd0) && ((dig_q >> {idx_q, 2'b00}) == 24'd0);
`else
    blank = 1'b0;
`endif
    sel_d = 6'b000001 << idx_q;
    seg_d = {~point[idx_q], blank ? 7'h7F : pat};
    if (!seg_en) begin
      sel_d = '0;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      bcd_q     <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      sel_q     <= '0;
      seg_q     <= 8'hFF;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      bcd_q     <= bcd_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule
